// File: rtl/qed_issue_ctrl.sv
// Purpose : batches generator instructions to two QED core copies (cpu0 original, cpu1 duplicate), then drains and pulses qed_check.
// Latency : an accepted instruction is offered to both cores the next cycle; one instruction per 2 cycles at best.
// Backpres: gen_ready drops while the holding register is full; each core handshakes independently via cpuX_ready.
// Build   : define QED_REG_MAP_EN to send a register-remapped copy to cpu1; otherwise cpu1 gets an identical copy.
module qed_issue_ctrl #(
    parameter int BATCH_LEN = 16,
    parameter int CNT_W     = 8,
    parameter int DRAIN_TO  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gen_valid,
    input  logic [31:0]      gen_inst,
    output logic             gen_ready,
    output logic             cpu0_valid,
    output logic [31:0]      cpu0_inst,
    input  logic             cpu0_ready,
    output logic             cpu1_valid,
    output logic [31:0]      cpu1_inst,
    input  logic             cpu1_ready,
    input  logic             cpu0_retire,
    input  logic             cpu1_retire,
    output logic             busy,
    output logic             qed_check,
    output logic             opcode_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam int DW = (DRAIN_TO > 1) ? $clog2(DRAIN_TO + 1) : 1;
    localparam logic [CNT_W-1:0] BATCH_LAST = CNT_W'(BATCH_LEN);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_TO - 1);
    localparam logic [6:0]       OPC_OP     = 7'b0110011;
    localparam logic [6:0]       OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t           state;
    logic             full;
    logic             taken0;
    logic             taken1;
    logic [CNT_W-1:0] ret0;
    logic [CNT_W-1:0] ret1;
    logic [DW-1:0]    drain_cnt;

    logic             op_ok;
    logic [31:0]      dup_inst;
    logic             acc0;
    logic             acc1;
    logic             both_done;
    logic [CNT_W-1:0] issued_next;
    logic             count_retires;

    // Only register-register and register-immediate ALU ops are safe to duplicate.
    assign op_ok = (gen_inst[6:0] == OPC_OP) || (gen_inst[6:0] == OPC_OP_IMM);

`ifdef QED_REG_MAP_EN
    // Mirror the register file: 1..12 <-> 12..1 and 13..31 <-> 31..13, x0 stays x0.
    function automatic logic [4:0] remap_reg(input logic [4:0] r);
        logic [5:0] wide;
        if (r == 5'd0) begin
            wide = 6'd0;
        end else if (r <= 5'd12) begin
            wide = 6'd13 - {1'b0, r};
        end else begin
            wide = 6'd44 - {1'b0, r};
        end
        return wide[4:0];
    endfunction

    // Build cpu1's copy: rd and rs1 always remapped, rs2 only for OP (OP_IMM keeps its immediate).
    always_comb begin
        dup_inst        = gen_inst;
        dup_inst[11:7]  = remap_reg(gen_inst[11:7]);
        dup_inst[19:15] = remap_reg(gen_inst[19:15]);
        if (gen_inst[6:0] == OPC_OP) begin
            dup_inst[24:20] = remap_reg(gen_inst[24:20]);
        end
    end
`else
    assign dup_inst = gen_inst;
`endif

    assign acc0          = cpu0_valid & cpu0_ready;
    assign acc1          = cpu1_valid & cpu1_ready;
    // An instruction is issued once both cores have it, whether in the same cycle or not.
    assign both_done     = full & (taken0 | acc0) & (taken1 | acc1);
    assign issued_next   = issued_cnt + CNT_W'(1);
    assign count_retires = (state == S_ISSUE) || (state == S_DRAIN);

    assign gen_ready = (state == S_ISSUE) && !full;
    assign busy      = (state != S_IDLE);

    // Batch sequencer, holding register, per-core handshakes and retire accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            full        <= 1'b0;
            taken0      <= 1'b0;
            taken1      <= 1'b0;
            cpu0_valid  <= 1'b0;
            cpu1_valid  <= 1'b0;
            cpu0_inst   <= '0;
            cpu1_inst   <= '0;
            ret0        <= '0;
            ret1        <= '0;
            issued_cnt  <= '0;
            drain_cnt   <= '0;
            qed_check   <= 1'b0;
            opcode_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            qed_check  <= 1'b0;
            opcode_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_ISSUE;
                        issued_cnt  <= '0;
                        ret0        <= '0;
                        ret1        <= '0;
                        timeout_err <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    if (full) begin
                        if (both_done) begin
                            full       <= 1'b0;
                            taken0     <= 1'b0;
                            taken1     <= 1'b0;
                            cpu0_valid <= 1'b0;
                            cpu1_valid <= 1'b0;
                            issued_cnt <= issued_next;
                            if (issued_next == BATCH_LAST) begin
                                state     <= S_DRAIN;
                                drain_cnt <= '0;
                            end
                        end else begin
                            if (acc0) begin
                                taken0     <= 1'b1;
                                cpu0_valid <= 1'b0;
                            end
                            if (acc1) begin
                                taken1     <= 1'b1;
                                cpu1_valid <= 1'b0;
                            end
                        end
                    end else if (gen_valid) begin
                        if (op_ok) begin
                            full       <= 1'b1;
                            cpu0_valid <= 1'b1;
                            cpu1_valid <= 1'b1;
                            cpu0_inst  <= gen_inst;
                            cpu1_inst  <= dup_inst;
                        end else begin
                            opcode_err <= 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    if ((ret0 == issued_cnt) && (ret1 == issued_cnt)) begin
                        state     <= S_CHECK;
                        qed_check <= 1'b1;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end

                S_CHECK: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A core retiring more than was issued is flagged and its count pinned.
            if (count_retires) begin
                if (cpu0_retire) begin
                    if (ret0 >= issued_cnt) begin
                        timeout_err <= 1'b1;
                    end else begin
                        ret0 <= ret0 + CNT_W'(1);
                    end
                end
                if (cpu1_retire) begin
                    if (ret1 >= issued_cnt) begin
                        timeout_err <= 1'b1;
                    end else begin
                        ret1 <= ret1 + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
